// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg: shared widths, block state and ADC code conversion for adc_cond
package adc_cond_pkg;
  localparam int DW_DEF = 10;
  localparam int AVG_LOG2_DEF = 10;
  typedef enum logic {WARMUP, RUN} state_t;
  function automatic logic [31:0] ob2tc(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/adc_cond_sat_sub.sv
// sat_sub: signed a - b clamped to DW bits, plus |a - b| clamped to 2^(DW-1)
module sat_sub #(
  parameter int DW = 10
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] diff,
  output logic        [DW-1:0] mag
);
  localparam logic [DW:0] LIM = (DW+1)'(1) << (DW - 1);
  logic signed [DW:0] d;
  logic [DW:0] ad;
  always_comb begin
    d = (DW+1)'(a) - (DW+1)'(b);
    ad = d[DW] ? -d : d;
    diff = (d[DW] != d[DW-1]) ? {d[DW], {(DW-1){~d[DW]}}} : d[DW-1:0];
    mag = (ad > LIM) ? LIM[DW-1:0] : ad[DW-1:0];
  end
endmodule

// File: rtl/adc_cond.sv
// adc_cond: ADC capture, offset-binary conversion, block-mean DC removal with saturation,
// and per-block peak / clip-overload statistics.
module adc_cond import adc_cond_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int CLIP_TH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DW-1:0]        data_in,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dc_est,
  output logic                 dc_valid,
  output logic                 block_done,
  output logic [DW-1:0]        peak,
  output logic                 ovl
);
  localparam int AW = DW + AVG_LOG2;
  localparam int CW = $clog2(CLIP_TH + 1);
  logic [DW-1:0] s1;
  logic signed [DW-1:0] s2, diff;
  logic [DW-1:0] mag, pk, pk_nxt;
  logic c2, take, last;
  logic [2:0] v;
  logic signed [AW-1:0] acc, acc_sum;
  logic [AVG_LOG2-1:0] cnt;
  logic [CW-1:0] clip, clip_nxt;
  state_t state, state_nxt;

  sat_sub #(.DW(DW)) u_sub (.a(s2), .b(dc_est), .diff(diff), .mag(mag));

  // c2 marks that the sample now in s2 came from a rail code in s1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      c2 <= 1'b0;
      v <= '0;
      dout <= '0;
    end else begin
      s1 <= data_in;
      s2 <= DW'(ob2tc(32'(s1), DW));
      c2 <= (s1 == '0) || (&s1);
      v <= {v[1:0], 1'b1};
      dout <= diff;
    end

  always_comb begin
    take = v[1] && en;
    last = take && (&cnt);
    acc_sum = acc + AW'(s2);
    pk_nxt = (mag > pk) ? mag : pk;
    clip_nxt = (c2 && clip != CW'(CLIP_TH)) ? clip + CW'(1) : clip;
    state_nxt = clr ? WARMUP : last ? RUN : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WARMUP;
    else state <= state_nxt;

  assign dc_valid = (state == RUN);
  assign dout_valid = v[2];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      pk <= '0;
      clip <= '0;
      dc_est <= '0;
      peak <= '0;
      ovl <= 1'b0;
      block_done <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      pk <= '0;
      clip <= '0;
      dc_est <= '0;
      peak <= '0;
      ovl <= 1'b0;
      block_done <= 1'b0;
    end else begin
      block_done <= last;
      if (last) begin
        dc_est <= DW'(acc_sum >>> AVG_LOG2);
        peak <= pk_nxt;
        ovl <= clip_nxt >= CW'(CLIP_TH);
        acc <= '0;
        cnt <= '0;
        pk <= '0;
        clip <= '0;
      end else if (take) begin
        acc <= acc_sum;
        cnt <= cnt + AVG_LOG2'(1);
        pk <= pk_nxt;
        clip <= clip_nxt;
      end
    end
endmodule

// File: tb/tb_adc_cond.sv
// tb_adc_cond: directed checks of adc_cond pipeline, DC removal, block statistics, clr, en and reset
module tb_adc_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] dout, dc_est, peak;
  logic dout_valid, dc_valid, block_done, ovl;
  int npass = 0;
  int nfail = 0;
  int ntot = 0;

  adc_cond dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .data_in(data_in),
    .dout(dout), .dout_valid(dout_valid), .dc_est(dc_est), .dc_valid(dc_valid),
    .block_done(block_done), .peak(peak), .ovl(ovl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_start();
    rst_n = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values
    step(2);
    chk("rst_dout", int'($signed(dout)), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dc_est", int'($signed(dc_est)), 0);
    chk("rst_dc_valid", int'(dc_valid), 0);
    chk("rst_block_done", int'(block_done), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_ovl", int'(ovl), 0);

    // constant +100
    data_in = 10'd612;
    reset_start();
    step(2);
    chk("t1_valid_e2", int'(dout_valid), 0);
    step(1);
    chk("t1_valid_e3", int'(dout_valid), 1);
    chk("t1_dout_e3", int'($signed(dout)), 100);
    step(1022);
    chk("t1_bd_e1025", int'(block_done), 0);
    chk("t1_dcv_e1025", int'(dc_valid), 0);
    step(1);
    chk("t1_bd_e1026", int'(block_done), 1);
    chk("t1_dc_e1026", int'($signed(dc_est)), 100);
    chk("t1_dcv_e1026", int'(dc_valid), 1);
    chk("t1_peak_e1026", int'(peak), 100);
    chk("t1_ovl_e1026", int'(ovl), 0);
    chk("t1_dout_e1026", int'($signed(dout)), 100);
    step(1);
    chk("t1_dout_e1027", int'($signed(dout)), 0);
    chk("t1_bd_e1027", int'(block_done), 0);
    step(1023);
    chk("t1_bd_e2050", int'(block_done), 1);
    chk("t1_peak_e2050", int'(peak), 0);
    chk("t1_dc_e2050", int'($signed(dc_est)), 100);

    // -300 block, then saturation
    data_in = 10'd212;
    reset_start();
    step(1024);
    data_in = 10'd1023;
    step(2);
    chk("t2_bd", int'(block_done), 1);
    chk("t2_dc", int'($signed(dc_est)), -300);
    step(1);
    chk("t2_sat_pos", int'($signed(dout)), 511);
    data_in = 10'd0;
    step(3);
    chk("t2_neg", int'($signed(dout)), -212);

    // alternating rails, then a block with 3 clips
    reset_start();
    for (int i = 1; i <= 2048; i++) begin
      data_in = (i <= 1024) ? ((i % 2) ? 10'd0 : 10'd1023)
              : ((i == 1030 || i == 1040 || i == 1050) ? 10'd0 : 10'd612);
      @(negedge clk);
      if (i == 1026) begin
        chk("t3_bd1", int'(block_done), 1);
        chk("t3_ovl1", int'(ovl), 1);
        chk("t3_dc1", int'($signed(dc_est)), -1);
        chk("t3_peak1", int'(peak), 512);
      end
    end
    step(2);
    chk("t3_bd2", int'(block_done), 1);
    chk("t3_ovl2", int'(ovl), 0);
    chk("t3_dc2", int'($signed(dc_est)), 98);
    chk("t3_peak2", int'(peak), 511);

    // clr mid-block and coincident with block end
    data_in = 10'd612;
    reset_start();
    step(502);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(523);
    chk("t4_bd_e1026", int'(block_done), 0);
    step(500);
    chk("t4_bd_e1526", int'(block_done), 0);
    step(1);
    chk("t4_bd_e1527", int'(block_done), 1);
    chk("t4_dc_e1527", int'($signed(dc_est)), 100);
    chk("t4_dcv_e1527", int'(dc_valid), 1);
    step(1023);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_bd_clr", int'(block_done), 0);
    chk("t4_dc_clr", int'($signed(dc_est)), 0);
    chk("t4_dcv_clr", int'(dc_valid), 0);
    chk("t4_dout_clr", int'($signed(dout)), 0);
    step(1);
    chk("t4_dout_after", int'($signed(dout)), 100);
    step(1022);
    chk("t4_bd_e3574", int'(block_done), 0);
    step(1);
    chk("t4_bd_e3575", int'(block_done), 1);
    chk("t4_dcv_e3575", int'(dc_valid), 1);

    // en low for 200 edges, disabled samples differ
    reset_start();
    for (int i = 1; i <= 1226; i++) begin
      data_in = (i >= 499 && i <= 698) ? 10'd212 : 10'd612;
      en = !(i >= 501 && i <= 700);
      @(negedge clk);
      if (i == 1026) chk("t5_bd_e1026", int'(block_done), 0);
      if (i == 1225) chk("t5_bd_e1225", int'(block_done), 0);
    end
    en = 1'b1;
    chk("t5_bd_e1226", int'(block_done), 1);
    chk("t5_dc", int'($signed(dc_est)), 100);
    chk("t5_peak", int'(peak), 100);

    // asynchronous reset between edges
    data_in = 10'd612;
    step(300);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_dout", int'($signed(dout)), 0);
    chk("t6_valid", int'(dout_valid), 0);
    chk("t6_dc", int'($signed(dc_est)), 0);
    chk("t6_dcv", int'(dc_valid), 0);
    chk("t6_peak", int'(peak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("t6_valid_e2", int'(dout_valid), 0);
    step(1);
    chk("t6_valid_e3", int'(dout_valid), 1);
    step(1022);
    chk("t6_bd_e1025", int'(block_done), 0);
    step(1);
    chk("t6_bd_e1026", int'(block_done), 1);
    chk("t6_dcv_e1026", int'(dc_valid), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
